dmem_arbiter: RTL and testbench

- Two-port arbiter sharing the single-port data memory (dm) between the CPU load/store path (port 0) and a debug/DMA loader (port 1).
- Issues at most one memory access per cycle, using round-robin priority.
- Returns read data registered, one cycle after the grant.
- Sits between the core datapath and the dm instance inside risc_top. Port 0 uses the stall output to freeze the PC.

---
 rtl/dmem_arbiter_if.sv | 58 +++++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the single-port RAM port shared by dmem_arbiter.
// With DMEM_ARB_LOCK_EN defined, port 1 also carries p1_lock.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_stall;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_stall;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic              p1_lock;
`endif

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_stall, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_stall, p1_rvalid, p1_rdata,
`ifdef DMEM_ARB_LOCK_EN
    input  p1_lock,
`endif
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Environment side: both requesters plus the RAM.
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_stall, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_stall, p1_rvalid, p1_rdata,
`ifdef DMEM_ARB_LOCK_EN
    output p1_lock,
`endif
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the CPU (port 0) and a DMA/debug loader (port 1).
// Optional DMEM_ARB_LOCK_EN adds p1_lock, letting port 1 hold the RAM across consecutive accesses.
module dmem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          areset,
  dmem_arbiter_if.slave bus
);
  logic              r_prio;
  logic              r_p0_rvalid;
  logic              r_p1_rvalid;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;

  logic              w_p0_gnt;
  logic              w_p1_gnt;
  logic              w_lock_hold;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

`ifdef DMEM_ARB_LOCK_EN
  logic r_locked;
  assign w_lock_hold = r_locked & bus.p1_lock;
`else
  assign w_lock_hold = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns both grants and no latch is inferred.
    w_p0_gnt = 1'b0;
    w_p1_gnt = 1'b0;
    if (areset) begin
      if (w_lock_hold) begin
        w_p1_gnt = bus.p1_req;
      end else if (bus.p0_req && bus.p1_req) begin
        w_p0_gnt = ~r_prio;
        w_p1_gnt = r_prio;
      end else begin
        w_p0_gnt = bus.p0_req;
        w_p1_gnt = bus.p1_req;
      end
    end
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_p0_gnt) begin
      w_mem_we    = bus.p0_we;
      w_mem_addr  = bus.p0_addr;
      w_mem_wdata = bus.p0_wdata;
    end else if (w_p1_gnt) begin
      w_mem_we    = bus.p1_we;
      w_mem_addr  = bus.p1_addr;
      w_mem_wdata = bus.p1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      r_prio      <= 1'b0;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
`ifdef DMEM_ARB_LOCK_EN
      r_locked    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values; the lock-release prio override below wins as the later assignment.
      if (w_p0_gnt) begin
        r_prio <= 1'b1;
      end else if (w_p1_gnt) begin
        r_prio <= 1'b0;
      end
      r_p0_rvalid <= w_p0_gnt & ~bus.p0_we;
      r_p1_rvalid <= w_p1_gnt & ~bus.p1_we;
      if (w_p0_gnt && !bus.p0_we) r_p0_rdata <= bus.mem_rdata;
      if (w_p1_gnt && !bus.p1_we) r_p1_rdata <= bus.mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
      if (r_locked && !bus.p1_lock) begin
        r_locked <= 1'b0;
        r_prio   <= 1'b0;
      end else if (w_p1_gnt && bus.p1_lock) begin
        r_locked <= 1'b1;
      end
`endif
    end
  end

  assign bus.p0_gnt    = w_p0_gnt;
  assign bus.p1_gnt    = w_p1_gnt;
  assign bus.p0_stall  = bus.p0_req & ~w_p0_gnt;
  assign bus.p1_stall  = bus.p1_req & ~w_p1_gnt;
  // A response already registered when reset arrives is hidden for the reset cycle.
  assign bus.p0_rvalid = r_p0_rvalid & areset;
  assign bus.p1_rvalid = r_p1_rvalid & areset;
  assign bus.p0_rdata  = r_p0_rdata;
  assign bus.p1_rdata  = r_p1_rdata;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus randomized traffic,
// all compared every cycle against a transaction-level model of the arbiter and RAM.
module tb_dmem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic areset = 1'b0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial forever #5 clk = ~clk;

  // Environment RAM: combinational read, write at the clock edge.
  logic [DW-1:0] ram [64] = '{default: '0};
  assign bus.mem_rdata = ram[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model state.
  bit            m_started = 1'b0;
  int            m_prio    = 0;
  bit            m_locked  = 1'b0;
  bit            m_rv [2]  = '{1'b0, 1'b0};
  logic [DW-1:0] m_rd [2]  = '{'0, '0};
  logic [DW-1:0] m_ram [64] = '{default: '0};
  bit            m_g0 = 1'b0;
  bit            m_g1 = 1'b0;

  initial forever begin
    int            win;
    bit            lk;
    req_t          r [2];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    bit            exp_we;
    @(negedge clk);
    r[0] = '{bus.p0_req, bus.p0_we, bus.p0_addr, bus.p0_wdata};
    r[1] = '{bus.p1_req, bus.p1_we, bus.p1_addr, bus.p1_wdata};
    lk = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    lk = bus.p1_lock;
`endif
    win = -1;
    if (areset) begin
      if (m_locked && lk)          win = r[1].req ? 1 : -1;
      else if (r[0].req && r[1].req) win = m_prio;
      else if (r[0].req)           win = 0;
      else if (r[1].req)           win = 1;
    end
    m_g0 = (win == 0);
    m_g1 = (win == 1);
    exp_we    = (win >= 0) ? r[win].we    : 1'b0;
    exp_addr  = (win >= 0) ? r[win].addr  : '0;
    exp_wdata = (win >= 0) ? r[win].wdata : '0;
    if (m_started) begin
      check("p0_gnt",    bus.p0_gnt,    DW'(m_g0));
      check("p1_gnt",    bus.p1_gnt,    DW'(m_g1));
      check("p0_stall",  bus.p0_stall,  DW'(r[0].req && !m_g0));
      check("p1_stall",  bus.p1_stall,  DW'(r[1].req && !m_g1));
      check("mem_we",    bus.mem_we,    DW'(exp_we));
      check("mem_addr",  bus.mem_addr,  DW'(exp_addr));
      check("mem_wdata", bus.mem_wdata, exp_wdata);
      check("p0_rvalid", bus.p0_rvalid, DW'(m_rv[0] && areset));
      check("p1_rvalid", bus.p1_rvalid, DW'(m_rv[1] && areset));
      check("p0_rdata",  bus.p0_rdata,  m_rd[0]);
      check("p1_rdata",  bus.p1_rdata,  m_rd[1]);
    end
    // Advance the model to the state after the coming rising edge.
    if (!areset) begin
      m_prio   = 0;
      m_locked = 1'b0;
      m_rv     = '{1'b0, 1'b0};
      m_rd     = '{'0, '0};
    end else begin
      m_rv = '{1'b0, 1'b0};
      if (win >= 0) begin
        if (r[win].we) m_ram[r[win].addr] = r[win].wdata;
        else begin
          m_rv[win] = 1'b1;
          m_rd[win] = m_ram[r[win].addr];
        end
        m_prio = (win == 0) ? 1 : 0;
        if (win == 1 && lk) m_locked = 1'b1;
      end
      if (m_locked && !lk) begin
        m_locked = 1'b0;
        m_prio   = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input req_t v);
    bus.p0_req = v.req; bus.p0_we = v.we; bus.p0_addr = v.addr; bus.p0_wdata = v.wdata;
  endtask

  task automatic set_p1(input req_t v);
    bus.p1_req = v.req; bus.p1_we = v.we; bus.p1_addr = v.addr; bus.p1_wdata = v.wdata;
  endtask

  task automatic set_lock(input bit v);
`ifdef DMEM_ARB_LOCK_EN
    bus.p1_lock = v;
`else
    if (v) $display("note: lock requested in a build without it");
`endif
  endtask

  task automatic idle();
    set_p0('0);
    set_p1('0);
    set_lock(1'b0);
  endtask

  // Random requester: hold a pending request until granted, occasionally cancel it.
  task automatic gen_req(input req_t cur, input bit granted, output req_t nxt);
    nxt = cur;
    if (cur.req && !granted) begin
      if ($urandom_range(9) == 0) nxt.req = 1'b0;
    end else begin
      nxt.req   = ($urandom_range(9) < 6);
      nxt.we    = $urandom_range(1) == 1;
      nxt.addr  = AW'($urandom_range(63));
      nxt.wdata = $urandom;
    end
  endtask

  initial begin
    req_t a;
    req_t b;
    idle();
    areset = 1'b0;

    // Reset held for two edges with both ports requesting.
    set_p0('{1'b1, 1'b0, 6'd0, 32'd0});
    set_p1('{1'b1, 1'b0, 6'd1, 32'd0});
    next_cycle();
    m_started = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_p0_gnt",    bus.p0_gnt,    32'd0);
      check("rst_p1_gnt",    bus.p1_gnt,    32'd0);
      check("rst_mem_we",    bus.mem_we,    32'd0);
      check("rst_p0_rvalid", bus.p0_rvalid, 32'd0);
      check("rst_p1_rvalid", bus.p1_rvalid, 32'd0);
      if (i == 0) next_cycle();
    end
    next_cycle();
    areset = 1'b1;
    @(negedge clk);
    check("rel_p0_first", bus.p0_gnt, 32'd1);
    check("rel_p1_wait",  bus.p1_gnt, 32'd0);
    next_cycle();
    set_p0('0);
    @(negedge clk);
    check("rel_p1_next", bus.p1_gnt, 32'd1);
    next_cycle();
    idle();

    // Continuous write contention: strict alternation starting at port 0.
    set_p0('{1'b1, 1'b1, 6'd1, 32'h11});
    set_p1('{1'b1, 1'b1, 6'd2, 32'h22});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cont_p0_gnt",   bus.p0_gnt,   DW'(i % 2 == 0));
      check("cont_p1_gnt",   bus.p1_gnt,   DW'(i % 2 == 1));
      check("cont_p0_stall", bus.p0_stall, DW'(i % 2 == 1));
      next_cycle();
    end
    idle();
    check("cont_ram1", ram[1], 32'h11);
    check("cont_ram2", ram[2], 32'h22);

    // Preload ram[5] through port 1, then a single port 0 read.
    set_p1('{1'b1, 1'b1, 6'd5, 32'hDEADBEEF});
    next_cycle();
    set_p1('0);
    set_p0('{1'b1, 1'b0, 6'd5, 32'd0});
    @(negedge clk);
    check("rd_p0_gnt", bus.p0_gnt, 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    check("rd_p0_rvalid", bus.p0_rvalid, 32'd1);
    check("rd_p0_rdata",  bus.p0_rdata,  32'hDEADBEEF);
    check("rd_p1_rvalid", bus.p1_rvalid, 32'd0);

    // Write the top word, read it back the next cycle.
    next_cycle();
    set_p1('{1'b1, 1'b1, 6'd63, 32'h12345678});
    @(negedge clk);
    check("wr63_p1_gnt", bus.p1_gnt, 32'd1);
    next_cycle();
    set_p1('0);
    set_p0('{1'b1, 1'b0, 6'd63, 32'd0});
    next_cycle();
    idle();
    @(negedge clk);
    check("rd63_rvalid", bus.p0_rvalid, 32'd1);
    check("rd63_rdata",  bus.p0_rdata,  32'h12345678);

    // Reset right after a granted read.
    next_cycle();
    set_p0('{1'b1, 1'b0, 6'd2, 32'd0});
    @(negedge clk);
    check("mid_p0_gnt", bus.p0_gnt, 32'd1);
    next_cycle();
    set_p0('0);
    areset = 1'b0;
    @(negedge clk);
    check("mid_rvalid", bus.p0_rvalid, 32'd0);
    next_cycle();
    areset = 1'b1;
    set_p0('{1'b1, 1'b0, 6'd1, 32'd0});
    set_p1('{1'b1, 1'b0, 6'd2, 32'd0});
    @(negedge clk);
    check("mid_prio0", bus.p0_gnt, 32'd1);
    next_cycle();
    set_p0('0);
    next_cycle();
    idle();

`ifdef DMEM_ARB_LOCK_EN
    // Give port 0 the last grant so the first contended cycle favours port 1.
    set_p0('{1'b1, 1'b0, 6'd3, 32'd0});
    next_cycle();
    set_p0('{1'b1, 1'b0, 6'd4, 32'd0});
    set_p1('{1'b1, 1'b0, 6'd5, 32'd0});
    set_lock(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lock_p1_gnt",   bus.p1_gnt,   32'd1);
      check("lock_p0_stall", bus.p0_stall, 32'd1);
      next_cycle();
    end
    set_lock(1'b0);
    @(negedge clk);
    check("unlock_p0_gnt", bus.p0_gnt, 32'd1);
    next_cycle();
    idle();
`endif

    // Randomized traffic with occasional reset pulses.
    a = '0;
    b = '0;
    for (int c = 0; c < 1500; c++) begin
      next_cycle();
      if (!areset) areset = 1'b1;
      else if ($urandom_range(99) == 0) areset = 1'b0;
      gen_req(a, m_g0, a);
      gen_req(b, m_g1, b);
      set_p0(a);
      set_p1(b);
      if ($urandom_range(4) == 0) set_lock($urandom_range(2) != 0);
    end
    next_cycle();
    idle();
    areset = 1'b1;
    @(negedge clk);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
